// File: rtl/pyc_stream_packer_pkg.sv
// pyc_stream_packer_pkg
// Shared helpers for the stream packer. Holds pyc_clog2, which sizes the
// lane counter and the optional idle counter.
// No ports (package).
package pyc_stream_packer_pkg;

    // Ceiling log2 with a floor of one bit, so a counter is never zero-width.
    function automatic int pyc_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pyc_stream_packer.sv
// pyc_stream_packer
// Ready/valid width upsizer: packs RATIO consecutive WIDTH-bit words into one
// WIDTH*RATIO-bit beat. in_last closes a beat early; out_keep marks the
// populated lanes and out_last marks a beat closed by in_last.
//
// Optional feature macro: PYC_STREAM_PACKER_TIMEOUT_EN
//   When defined, a partial beat left idle for TIMEOUT cycles is flushed
//   with out_last=0. When undefined, a partial beat waits indefinitely.
//
// Ports:
//   clk        single clock
//   rst        synchronous active-high reset
//   in_valid   input word valid
//   in_ready   packer accepts the input word this cycle
//   in_data    input word (WIDTH bits)
//   in_last    final word of a packet, closes the current beat
//   out_valid  output beat valid
//   out_ready  consumer accepts the beat
//   out_data   packed beat, lane i = bits [i*WIDTH +: WIDTH]
//   out_keep   lane i holds valid data
//   out_last   beat was closed by in_last
module pyc_stream_packer
    import pyc_stream_packer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]       out_keep,
    output logic                   out_last
);

    localparam int CNT_W = pyc_clog2(RATIO);
    localparam int ACC_W = WIDTH * (RATIO - 1);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]       cnt;
    logic [ACC_W-1:0]       acc;
    logic                   out_valid_r;
    logic [WIDTH*RATIO-1:0] data_r;
    logic [RATIO-1:0]       keep_r;
    logic                   last_r;

    logic                   accept;
    logic                   complete;
    logic                   pop;
    logic                   flush;
    logic [WIDTH*RATIO-1:0] full_data;
    logic [RATIO-1:0]       full_keep;
    logic [WIDTH*RATIO-1:0] part_data;
    logic [RATIO-1:0]       part_keep;

    assign out_valid = out_valid_r;
    assign out_data  = data_r;
    assign out_keep  = keep_r;
    assign out_last  = last_r;

    // The stall rule is deliberately coarse: a held output beat blocks every
    // input word, even one that would only land in the accumulator.
    assign in_ready = ~out_valid_r | out_ready;
    assign accept   = in_valid & in_ready;
    assign complete = accept & (in_last | (cnt == LAST_LANE));
    assign pop      = out_valid_r & out_ready;

    // Candidate beats. Accumulator lanes at or above cnt are always zero,
    // so the incoming word can simply overwrite lane cnt.
    always_comb begin
        full_data = '0;
        full_keep = '0;
        part_data = '0;
        part_keep = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            full_data[i*WIDTH +: WIDTH] = acc[i*WIDTH +: WIDTH];
            part_data[i*WIDTH +: WIDTH] = acc[i*WIDTH +: WIDTH];
        end
        for (int i = 0; i < RATIO; i++) begin
            if (cnt == CNT_W'(i)) begin
                full_data[i*WIDTH +: WIDTH] = in_data;
            end
            full_keep[i] = (CNT_W'(i) <= cnt);
            part_keep[i] = (CNT_W'(i) < cnt);
        end
    end

`ifdef PYC_STREAM_PACKER_TIMEOUT_EN
    localparam int IDLE_W = pyc_clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);

    logic [IDLE_W-1:0] idle;

    // The flush loses to an accept and waits for a free or draining output
    // stage; the counter saturates at the limit while it waits.
    assign flush = ~accept & (cnt != '0) & (idle == IDLE_LIMIT) & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle <= '0;
        end else if (accept || flush || (cnt == '0)) begin
            idle <= '0;
        end else if (idle != IDLE_LIMIT) begin
            idle <= idle + IDLE_W'(1);
        end
    end
`else
    assign flush = 1'b0;
`endif

    // Output stage: a completing word or a flush reloads it (even while the
    // previous beat is being popped); otherwise a pop empties it to zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            data_r      <= '0;
            keep_r      <= '0;
            last_r      <= 1'b0;
        end else if (complete) begin
            out_valid_r <= 1'b1;
            data_r      <= full_data;
            keep_r      <= full_keep;
            last_r      <= in_last;
        end else if (flush) begin
            out_valid_r <= 1'b1;
            data_r      <= part_data;
            keep_r      <= part_keep;
            last_r      <= 1'b0;
        end else if (pop) begin
            out_valid_r <= 1'b0;
            data_r      <= '0;
            keep_r      <= '0;
            last_r      <= 1'b0;
        end
    end

    // Accumulator and lane count. Lanes are cleared on hand-off so the beat
    // builder can rely on unused lanes being zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (complete || flush) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            for (int i = 0; i < RATIO - 1; i++) begin
                if (cnt == CNT_W'(i)) begin
                    acc[i*WIDTH +: WIDTH] <= in_data;
                end
            end
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifndef SYNTHESIS
    initial begin
        if (RATIO < 2 || WIDTH < 1 || TIMEOUT < 1) begin
            $display("ERROR: pyc_stream_packer bad parameters WIDTH=%0d RATIO=%0d TIMEOUT=%0d",
                     WIDTH, RATIO, TIMEOUT);
            $finish;
        end
    end
`endif

endmodule
